// File: rtl/host_flr_pkg.sv
// -----------------------------------------------------------------------------
// host_flr_pkg
// Types and constants shared by the host-side FLR manager and its validator.
// -----------------------------------------------------------------------------
package host_flr_pkg;

    localparam int PF_W                   = 3;
    localparam int VF_W                   = 11;
    localparam int VF_CNT_W               = 12;
    localparam int MAX_PF                 = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        WAIT  = 2'd3
    } t_flr_state;

    // Same bit layout as the FLR side-band tdata.
    typedef struct packed {
        logic            vf_active;
        logic [VF_W-1:0] vf_num;
        logic [PF_W-1:0] pf_num;
    } t_flr_func;

endpackage : host_flr_pkg

// File: rtl/pcie_ss_axis_pkg.sv
// -----------------------------------------------------------------------------
// pcie_ss_axis_pkg
// Shared PCIe subsystem AXI-stream side-band types. Only the FLR side-band
// struct is needed by the host FLR manager.
//   t_axis_pcie_flr.tvalid : request/completion valid
//   t_axis_pcie_flr.tdata  : {vf_active, vf_num[10:0], pf_num[2:0]}
// -----------------------------------------------------------------------------
package pcie_ss_axis_pkg;

    localparam int FLR_TDATA_W = 15;

    typedef struct packed {
        logic                   tvalid;
        logic [FLR_TDATA_W-1:0] tdata;
    } t_axis_pcie_flr;

endpackage : pcie_ss_axis_pkg

// File: rtl/host_flr_func_check.sv
// -----------------------------------------------------------------------------
// host_flr_func_check
// Combinational validator for an FLR target function.
// A function is valid when its PF is below NUM_PF, the PF is enabled, and,
// for a VF target, the VF number is below that PF's configured VF count.
// Ports:
//   func  in  t_flr_func  function to validate
//   valid out 1           1 = function exists in the enabled configuration
// -----------------------------------------------------------------------------
module host_flr_func_check
    import host_flr_pkg::*;
#(
    parameter int                           NUM_PF         = 8,
    parameter logic [MAX_PF-1:0]            PF_ENABLED_VEC = 8'h01,
    parameter logic [MAX_PF*VF_CNT_W-1:0]   PF_NUM_VFS_VEC = '0
) (
    input  t_flr_func func,
    output logic      valid
);

    logic [MAX_PF-1:0] pf_ok;

    // One verdict per PF slot; the target PF then selects its own verdict.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_PF; gi++) begin : g_pf
            localparam logic PF_PRESENT = (gi < NUM_PF) && PF_ENABLED_VEC[gi];
            logic [VF_CNT_W-1:0] num_vfs;

            assign num_vfs   = PF_NUM_VFS_VEC[gi*VF_CNT_W +: VF_CNT_W];
            assign pf_ok[gi] = PF_PRESENT &&
                               (!func.vf_active || ({1'b0, func.vf_num} < num_vfs));
        end
    endgenerate

    assign valid = pf_ok[func.pf_num];

endmodule : host_flr_func_check

// File: rtl/host_flr_top.sv
// -----------------------------------------------------------------------------
// host_flr_top
// Host-side Function-Level Reset manager. Takes one FLR command at a time,
// validates the target, issues a single-cycle FLR request and waits for the
// matching completion, reporting done / invalid / unexpected / timeout events.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cmd_valid/ready   command handshake; ready only in IDLE
//   cmd_pf/vf/vf_active  target function
//   flr_req_if        FLR request (tvalid for exactly one cycle)
//   flr_rsp_if        FLR completion
//   busy              state is not IDLE
//   flr_done, err_invalid, err_unexpected, err_timeout  single-cycle pulses
//   flr_count         completed FLR count, saturating
// -----------------------------------------------------------------------------
module host_flr_top
    import host_flr_pkg::*;
#(
    parameter int                           NUM_PF         = 8,
    parameter logic [MAX_PF-1:0]            PF_ENABLED_VEC = 8'h01,
    parameter logic [MAX_PF*VF_CNT_W-1:0]   PF_NUM_VFS_VEC = '0,
    parameter int                           TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_pf,
    input  logic [10:0]                      cmd_vf,
    input  logic                             cmd_vf_active,
    output pcie_ss_axis_pkg::t_axis_pcie_flr flr_req_if,
    input  pcie_ss_axis_pkg::t_axis_pcie_flr flr_rsp_if,
    output logic                             busy,
    output logic                             flr_done,
    output logic                             err_invalid,
    output logic                             err_unexpected,
    output logic                             err_timeout,
    output logic [15:0]                      flr_count
);

    localparam int                 TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    t_flr_state         state_q, state_d;
    t_flr_func          func_q, func_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [15:0]        flr_count_q, flr_count_d;

    logic               func_valid;
    logic [14:0]        func_bits;
    logic               rsp_match;
    logic               done_c, invalid_c, unexpected_c, timeout_c;

    host_flr_func_check #(
        .NUM_PF         (NUM_PF),
        .PF_ENABLED_VEC (PF_ENABLED_VEC),
        .PF_NUM_VFS_VEC (PF_NUM_VFS_VEC)
    ) u_func_check (
        .func  (func_q),
        .valid (func_valid)
    );

    assign func_bits = func_q;
    assign rsp_match = flr_rsp_if.tvalid && (flr_rsp_if.tdata == func_bits);

    always_comb begin
        state_d      = state_q;
        func_d       = func_q;
        timer_d      = timer_q;
        flr_count_d  = flr_count_q;
        done_c       = 1'b0;
        invalid_c    = 1'b0;
        unexpected_c = 1'b0;
        timeout_c    = 1'b0;

        case (state_q)
            IDLE: begin
                unexpected_c = flr_rsp_if.tvalid;
                if (cmd_valid) begin
                    func_d.vf_active = cmd_vf_active;
                    func_d.vf_num    = cmd_vf_active ? cmd_vf : '0;
                    func_d.pf_num    = cmd_pf;
                    state_d          = CHECK;
                end
            end
            CHECK: begin
                unexpected_c = flr_rsp_if.tvalid;
                if (func_valid) begin
                    state_d = REQ;
                end else begin
                    invalid_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            REQ: begin
                unexpected_c = flr_rsp_if.tvalid;
                timer_d      = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                timer_d      = timer_q + TIMER_W'(1);
                unexpected_c = flr_rsp_if.tvalid && !rsp_match;
                // A match on the last timer cycle takes priority over timeout.
                if (rsp_match) begin
                    done_c = 1'b1;
                    if (flr_count_q != 16'hFFFF) begin
                        flr_count_d = flr_count_q + 16'd1;
                    end
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            func_q      <= '0;
            timer_q     <= '0;
            flr_count_q <= '0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            timer_q     <= timer_d;
            flr_count_q <= flr_count_d;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out of an
    // abandoned operation in the reset cycle itself.
    always_comb begin
        flr_req_if = '0;
        if (rst_n && (state_q == REQ)) begin
            flr_req_if.tvalid = 1'b1;
            flr_req_if.tdata  = func_bits;
        end
    end

    assign cmd_ready      = rst_n && (state_q == IDLE);
    assign busy           = rst_n && (state_q != IDLE);
    assign flr_done       = rst_n && done_c;
    assign err_invalid    = rst_n && invalid_c;
    assign err_unexpected = rst_n && unexpected_c;
    assign err_timeout    = rst_n && timeout_c;
    assign flr_count      = rst_n ? flr_count_q : 16'd0;

endmodule : host_flr_top

// File: tb/tb_host_flr_top.sv
module tb_host_flr_top;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_pf;
    logic [10:0] cmd_vf;
    logic        cmd_vf_active;
    pcie_ss_axis_pkg::t_axis_pcie_flr flr_req_if;
    pcie_ss_axis_pkg::t_axis_pcie_flr flr_rsp_if;
    logic        busy;
    logic        flr_done;
    logic        err_invalid;
    logic        err_unexpected;
    logic        err_timeout;
    logic [15:0] flr_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse tallies sampled on the falling edge, away from the active edge.
    int done_seen  = 0;
    int inv_seen   = 0;
    int unexp_seen = 0;
    int to_seen    = 0;
    int req_seen   = 0;

    host_flr_top #(
        .NUM_PF         (8),
        .PF_ENABLED_VEC (8'h03),
        .PF_NUM_VFS_VEC (96'h4000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_pf         (cmd_pf),
        .cmd_vf         (cmd_vf),
        .cmd_vf_active  (cmd_vf_active),
        .flr_req_if     (flr_req_if),
        .flr_rsp_if     (flr_rsp_if),
        .busy           (busy),
        .flr_done       (flr_done),
        .err_invalid    (err_invalid),
        .err_unexpected (err_unexpected),
        .err_timeout    (err_timeout),
        .flr_count      (flr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (flr_done)          done_seen  <= done_seen + 1;
        if (err_invalid)       inv_seen   <= inv_seen + 1;
        if (err_unexpected)    unexp_seen <= unexp_seen + 1;
        if (err_timeout)       to_seen    <= to_seen + 1;
        if (flr_req_if.tvalid) req_seen   <= req_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_ready);
        check({tag, "_ready"},   cmd_ready, exp_ready);
        check({tag, "_busy"},    busy, 1'b0);
        check({tag, "_done"},    flr_done, 1'b0);
        check({tag, "_inv"},     err_invalid, 1'b0);
        check({tag, "_unexp"},   err_unexpected, 1'b0);
        check({tag, "_to"},      err_timeout, 1'b0);
        check({tag, "_count"},   flr_count, 16'd0);
        check({tag, "_tvalid"},  flr_req_if.tvalid, 1'b0);
        check({tag, "_tdata"},   flr_req_if.tdata, 15'd0);
    endtask

    // Accepts a command and walks it through CHECK (and REQ when valid).
    // Returns in the first WAIT cycle for a valid target, else back in IDLE.
    task automatic do_cmd(input logic [2:0] pf, input logic va, input logic [10:0] vf,
                          input logic exp_ok, input logic [14:0] exp_tdata);
        cmd_pf        = pf;
        cmd_vf        = vf;
        cmd_vf_active = va;
        cmd_valid     = 1'b1;
        #1;
        check("cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        #1;
        check("check_busy", busy, 1'b1);
        check("check_err_invalid", err_invalid, !exp_ok);
        check("check_no_req", flr_req_if.tvalid, 1'b0);
        tick();
        if (exp_ok) begin
            check("req_tvalid", flr_req_if.tvalid, 1'b1);
            check("req_tdata", flr_req_if.tdata, exp_tdata);
            check("req_busy", busy, 1'b1);
            tick();
            check("wait_no_req", flr_req_if.tvalid, 1'b0);
            check("wait_tdata_zero", flr_req_if.tdata, 15'd0);
        end else begin
            check("inv_back_idle", busy, 1'b0);
            check("inv_ready", cmd_ready, 1'b1);
            check("inv_no_req", flr_req_if.tvalid, 1'b0);
        end
        $display("cmd pf=%0d vf_active=%0d vf=%0d -> %s", pf, va, vf, exp_ok ? "issued" : "rejected");
    endtask

    initial begin
        rst_n             = 1'b0;
        cmd_valid         = 1'b0;
        cmd_pf            = '0;
        cmd_vf            = '0;
        cmd_vf_active     = 1'b0;
        flr_rsp_if.tvalid = 1'b0;
        flr_rsp_if.tdata  = '0;

        // Reset held: everything low.
        #1;
        check_idle_outputs("in_reset", 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_idle_outputs("after_reset", 1'b1);

        // Stray 3-cycle response burst while idle.
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h7FFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stray_unexp", err_unexpected, 1'b1);
            check("stray_busy", busy, 1'b0);
            check("stray_ready", cmd_ready, 1'b1);
            tick();
        end
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("stray_unexp_total", unexp_seen, 3);
        $display("stray burst -> 3 unexpected responses");

        // PF0 itself; cmd_vf is ignored and forced to zero in the request.
        do_cmd(3'd0, 1'b0, 11'd5, 1'b1, 15'h0000);
        repeat (4) tick();
        check("pf0_no_early_done", done_seen, 0);
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h0000;
        #1;
        check("pf0_done", flr_done, 1'b1);
        check("pf0_no_unexp", err_unexpected, 1'b0);
        tick();
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("pf0_count", flr_count, 16'd1);
        check("pf0_busy_drop", busy, 1'b0);
        $display("flr pf0 -> done, count=%0d", flr_count);

        // PF1 VF3: mismatched completion first, then the right one.
        do_cmd(3'd1, 1'b1, 11'd3, 1'b1, 15'h4019);
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h4011;
        #1;
        check("vf_mismatch_unexp", err_unexpected, 1'b1);
        check("vf_mismatch_no_done", flr_done, 1'b0);
        tick();
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("vf_still_waiting", busy, 1'b1);
        tick();
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h4019;
        #1;
        check("vf_done", flr_done, 1'b1);
        tick();
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("vf_count", flr_count, 16'd2);
        check("vf_busy_drop", busy, 1'b0);
        $display("flr pf1 vf3 -> done, count=%0d", flr_count);

        // Rejected targets.
        do_cmd(3'd2, 1'b0, 11'd0, 1'b0, 15'h0000);
        do_cmd(3'd1, 1'b1, 11'd4, 1'b0, 15'h0000);
        do_cmd(3'd0, 1'b1, 11'd0, 1'b0, 15'h0000);
        check("inv_total", inv_seen, 3);
        check("inv_req_total", req_seen, 2);

        // Timeout after 16 WAIT cycles with no completion.
        do_cmd(3'd0, 1'b0, 11'd0, 1'b1, 15'h0000);
        check("to_not_early_c0", err_timeout, 1'b0);
        repeat (15) tick();
        check("to_not_early", to_seen, 0);
        check("to_pulse", err_timeout, 1'b1);
        check("to_no_done", flr_done, 1'b0);
        check("to_busy", busy, 1'b1);
        tick();
        check("to_idle", busy, 1'b0);
        check("to_count_hold", flr_count, 16'd2);
        $display("flr pf0 no response -> timeout");

        // Match on the 16th WAIT cycle beats the timeout.
        do_cmd(3'd1, 1'b1, 11'd0, 1'b1, 15'h4001);
        repeat (15) tick();
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h4001;
        #1;
        check("edge_done", flr_done, 1'b1);
        check("edge_no_to", err_timeout, 1'b0);
        tick();
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("edge_count", flr_count, 16'd3);
        check("edge_idle", busy, 1'b0);
        check("edge_to_total", to_seen, 1);
        $display("flr pf1 vf0 last-cycle response -> done, count=%0d", flr_count);

        // One-cycle reset in WAIT, with a response present that must be ignored.
        do_cmd(3'd0, 1'b0, 11'd0, 1'b1, 15'h0000);
        tick();
        rst_n             = 1'b0;
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h1234;
        #1;
        check_idle_outputs("mid_reset", 1'b0);
        tick();
        rst_n             = 1'b0;
        rst_n             = 1'b1;
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_count", flr_count, 16'd0);
        check("post_rst_ready", cmd_ready, 1'b1);
        $display("reset during wait -> abandoned");

        do_cmd(3'd1, 1'b0, 11'd7, 1'b1, 15'h0001);
        flr_rsp_if.tvalid = 1'b1;
        flr_rsp_if.tdata  = 15'h0001;
        #1;
        check("post_rst_done", flr_done, 1'b1);
        tick();
        flr_rsp_if.tvalid = 1'b0;
        #1;
        check("post_rst_count1", flr_count, 16'd1);
        check("post_rst_idle", busy, 1'b0);
        $display("flr pf1 after reset -> done, count=%0d", flr_count);

        // Totals over the whole run.
        check("total_done", done_seen, 4);
        check("total_invalid", inv_seen, 3);
        check("total_unexpected", unexp_seen, 4);
        check("total_timeout", to_seen, 1);
        check("total_req", req_seen, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_host_flr_top
